uart_tx_frame_arbiter: RTL and testbench
========================================

Name: uart_tx_frame_arbiter

Overview:
- Shares the single UART transmit byte stream (data/valid/ready of the UART driver TX path) between P_NUM_REQ requesters.
- Arbitration is round-robin at frame granularity: a grant is held from the first byte until the byte flagged last is accepted.
- A programmable inter-frame idle gap follows each frame.
- An idle watchdog aborts a frame whose owner stalls mid-frame.

Parameters:
- P_NUM_REQ, 4, number of requesters (2..8).
- P_DATA_WIDTH, 8, byte width; equals the UART driver data width.
- P_GAP_CYCLES, 2, idle i_clk cycles inserted after each frame; 0 means no gap.
- P_TIMEOUT_CYCLES, 1024, consecutive cycles with owner valid low mid-frame before abort (>=1).

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req_data  in  P_NUM_REQ*P_DATA_WIDTH  requester bytes; requester k uses bits [k*W +: W].
- i_req_valid  in  P_NUM_REQ  per-requester byte valid.
- i_req_last  in  P_NUM_REQ  per-requester last-byte-of-frame flag, qualified by valid.
- o_req_ready  out  P_NUM_REQ  per-requester ready.
- o_tx_data  out  P_DATA_WIDTH  byte to the UART driver TX input.
- o_tx_valid  out  1  byte valid to the UART driver.
- i_tx_ready  in  1  UART driver TX ready.
- o_grant  out  P_NUM_REQ  one-hot current owner; all zero when no owner.
- o_busy  out  1  high in XFER or GAP.
- o_timeout  out  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Handshake definitions:
  - Transfer occurs on a cycle with o_tx_valid & i_tx_ready.
  - A requester handshake is i_req_valid[k] & o_req_ready[k].
- Reset (i_rst_n low, asynchronous): state=IDLE, rr pointer=0, o_grant=0, o_tx_valid=0, o_tx_data=0, o_req_ready=0, o_busy=0, o_timeout=0, counters=0.
- FSM states: IDLE, XFER, GAP.
- IDLE:
  - If any i_req_valid is high, pick the first valid index searching from pointer, pointer+1, ... modulo P_NUM_REQ.
  - Register the one-hot grant and go to XFER on the next edge. Arbitration latency is 1 cycle.
  - The pointer becomes winner+1 modulo P_NUM_REQ.
  - With no valid requester, stay in IDLE.
- XFER (combinational passthrough from the owner g):
  - o_tx_data = owner data slice.
  - o_tx_valid = i_req_valid[g].
  - o_req_ready[g] = i_tx_ready; all other ready bits are 0.
  - Non-owners are never readied, even if their valid is high.
  - On a transfer with i_req_last[g]=1: clear grant, go to GAP (or to IDLE if P_GAP_CYCLES=0).
  - Timeout counter:
    - Increments each XFER cycle with i_req_valid[g]=0.
    - Clears on any cycle with valid high.
    - Clears on XFER entry.
    - On reaching P_TIMEOUT_CYCLES: pulse o_timeout for 1 cycle, clear grant, go to GAP.
    - The partial frame is abandoned; no bytes are re-sent.
- GAP:
  - o_tx_valid=0 and o_req_ready=0.
  - The gap counter counts P_GAP_CYCLES cycles, then the FSM returns to IDLE.
  - Arbitration occurs in IDLE only, so the next grant is registered no earlier than P_GAP_CYCLES+1 cycles after the last transfer.
- Frame boundaries:
  - A single-byte frame (first byte has last=1) is legal.
  - Frame length is unbounded.
- Valid/last timing: owner valid may drop between bytes without losing the grant (subject to timeout). i_req_last is sampled only on a transfer cycle.
- Pointer update is on the grant edge, not on frame end, so an aborted requester still loses priority.
- Simultaneous requests: exactly one grant. Requesters that lose must hold valid; starvation-free, with a worst-case wait of P_NUM_REQ-1 frames.
- Reset mid-frame: everything returns to reset values immediately; the in-flight byte is discarded.
- o_busy = (state != IDLE).
- o_grant is registered and glitch-free.

Test Plan:
- Reset, then req1 sends a 3-byte frame 0xA1,0xA2,0xA3 (last on 0xA3) with i_tx_ready=1. Required response:
  - o_grant=0010 one cycle after valid.
  - o_tx_data shows A1,A2,A3 on consecutive transfers.
  - GAP lasts 2 cycles, then IDLE with o_busy=0.
- All 4 requesters hold 1-byte frames (0x10,0x20,0x30,0x40) continuously. Required response: grants in order 0,1,2,3,0; each byte appears exactly once per round.
- req2 mid-frame while i_tx_ready is toggled 1,0,0,1. Required response:
  - o_req_ready[2] mirrors i_tx_ready.
  - Data holds while ready=0.
  - req0 valid during the frame gets no ready until req2's last byte is accepted.
- With P_TIMEOUT_CYCLES=16, req3 sends 0x55 and then drops valid. Required response: o_timeout pulses exactly 16 cycles later, grant clears, GAP, then the next requester is served.
- i_rst_n asserted during byte 2 of a 4-byte frame from req0. Required response:
  - Outputs zero immediately, asynchronously.
  - After release, arbitration restarts with pointer=0.
- P_GAP_CYCLES=0 build, req0 and req1 both pending. Required response: second grant registers in the cycle after IDLE is re-entered, i.e. the first byte of the next frame comes 2 cycles after the previous last transfer.

Source files
------------

// File: rtl/uart_tx_frame_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_frame_arbiter
//
// Shares one UART driver TX byte stream between P_NUM_REQ requesters.
// Ownership is granted round-robin per frame. It is held from the first byte
// until the byte flagged last is accepted, and a fixed idle gap follows.
// A watchdog abandons a frame whose owner stops presenting bytes.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_req_data       packed requester bytes, requester k at [k*W +: W]
//   i_req_valid      per-requester byte valid
//   i_req_last       per-requester last-byte flag (qualified by valid)
//   o_req_ready      per-requester ready (only the owner is ever readied)
//   o_tx_data        byte to the UART driver
//   o_tx_valid       byte valid to the UART driver
//   i_tx_ready       UART driver ready
//   o_grant          one-hot current owner, zero when none
//   o_busy           high while a frame or its idle gap is in progress
//   o_timeout        one-cycle pulse when a stalled frame is abandoned
// ---------------------------------------------------------------------------
module uart_tx_frame_arbiter #(
    parameter int P_NUM_REQ        = 4,
    parameter int P_DATA_WIDTH     = 8,
    parameter int P_GAP_CYCLES     = 2,
    parameter int P_TIMEOUT_CYCLES = 1024
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] i_req_data,
    input  logic [P_NUM_REQ-1:0]              i_req_valid,
    input  logic [P_NUM_REQ-1:0]              i_req_last,
    output logic [P_NUM_REQ-1:0]              o_req_ready,
    output logic [P_DATA_WIDTH-1:0]           o_tx_data,
    output logic                              o_tx_valid,
    input  logic                              i_tx_ready,
    output logic [P_NUM_REQ-1:0]              o_grant,
    output logic                              o_busy,
    output logic                              o_timeout
);

    localparam int IW = (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1;
    localparam int TW = (P_TIMEOUT_CYCLES > 1) ? $clog2(P_TIMEOUT_CYCLES) : 1;
    localparam int GW = (P_GAP_CYCLES > 1) ? $clog2(P_GAP_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST  = TW'(P_TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((P_GAP_CYCLES > 0) ? P_GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t               state_q;
    logic [P_NUM_REQ-1:0] grant_q;
    logic [IW-1:0]        owner_q;
    logic [IW-1:0]        ptr_q;
    logic [TW-1:0]        to_cnt_q;
    logic [GW-1:0]        gap_cnt_q;
    logic                 busy_q;
    logic                 timeout_q;

    // Requester index 'off' positions after 'base', wrapping at P_NUM_REQ.
    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= P_NUM_REQ) s = s - P_NUM_REQ;
        return IW'(s);
    endfunction

    // Round-robin search starting at the pointer. Scanning from the farthest
    // offset down lets the nearest valid requester overwrite earlier hits.
    logic          any_valid;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] ptr_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        any_valid = 1'b0;
        win_idx   = '0;
        for (int i = P_NUM_REQ - 1; i >= 0; i--) begin
            if (i_req_valid[rr_idx(ptr_q, i)]) begin
                any_valid = 1'b1;
                win_idx   = rr_idx(ptr_q, i);
            end
        end
        ptr_d = (win_idx == IW'(P_NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end

    // Owner passthrough; everything is gated off outside XFER.
    logic in_xfer;
    logic owner_valid;
    logic tx_fire;
    logic abort;
    logic frame_end;

    assign in_xfer     = (state_q == ST_XFER);
    assign owner_valid = in_xfer & i_req_valid[owner_q];
    assign tx_fire     = owner_valid & i_tx_ready;
    assign abort       = in_xfer & ~i_req_valid[owner_q] & (to_cnt_q == TO_LAST);
    assign frame_end   = (tx_fire & i_req_last[owner_q]) | abort;

    assign o_tx_valid  = owner_valid;
    assign o_tx_data   = in_xfer ? i_req_data[int'(owner_q)*P_DATA_WIDTH +: P_DATA_WIDTH] : '0;
    assign o_req_ready = (in_xfer & i_tx_ready) ? grant_q : '0;
    assign o_grant     = grant_q;
    assign o_busy      = busy_q;
    assign o_timeout   = timeout_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: counters and pointer are control state, so all of them are reset, not just the FSM.
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            to_cnt_q  <= '0;
            gap_cnt_q <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            timeout_q <= abort;
            case (state_q)
                ST_IDLE: begin
                    if (any_valid) begin
                        state_q  <= ST_XFER;
                        grant_q  <= {{(P_NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
                        owner_q  <= win_idx;
                        // Priority moves on at grant time, so an aborted owner still loses its turn.
                        ptr_q    <= ptr_d;
                        to_cnt_q <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                ST_XFER: begin
                    if (frame_end) begin
                        grant_q   <= '0;
                        to_cnt_q  <= '0;
                        gap_cnt_q <= '0;
                        if (P_GAP_CYCLES == 0) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_GAP;
                        end
                    end else if (owner_valid) begin
                        to_cnt_q <= '0;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_frame_arbiter
//
// Two arbiters share the same stimulus: A has a 2-cycle gap, B has no gap.
// Both use a 16-cycle watchdog. A per-cycle vector table and a few
// hand-written sequences cover the directed scenarios. Random traffic is then
// compared against a frame-level reference model.
// ---------------------------------------------------------------------------
module tb_uart_tx_frame_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int GAP_A = 2;
    localparam int TO    = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic           tx_ready;

    logic [N-1:0] a_ready, a_grant, b_ready, b_grant;
    logic [W-1:0] a_data, b_data;
    logic         a_valid, a_busy, a_timeout, b_valid, b_busy, b_timeout;

    always #5 clk = ~clk;

    uart_tx_frame_arbiter #(
        .P_NUM_REQ(N), .P_DATA_WIDTH(W), .P_GAP_CYCLES(GAP_A), .P_TIMEOUT_CYCLES(TO)
    ) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_data(req_data), .i_req_valid(req_valid),
        .i_req_last(req_last), .o_req_ready(a_ready), .o_tx_data(a_data), .o_tx_valid(a_valid),
        .i_tx_ready(tx_ready), .o_grant(a_grant), .o_busy(a_busy), .o_timeout(a_timeout)
    );

    uart_tx_frame_arbiter #(
        .P_NUM_REQ(N), .P_DATA_WIDTH(W), .P_GAP_CYCLES(0), .P_TIMEOUT_CYCLES(TO)
    ) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_data(req_data), .i_req_valid(req_valid),
        .i_req_last(req_last), .o_req_ready(b_ready), .o_tx_data(b_data), .o_tx_valid(b_valid),
        .i_tx_ready(tx_ready), .o_grant(b_grant), .o_busy(b_busy), .o_timeout(b_timeout)
    );

    typedef struct {
        logic [N-1:0] grant;
        logic         tx_valid;
        logic [W-1:0] tx_data;
        logic [N-1:0] ready;
        logic         busy;
        logic         timeout;
    } outs_t;

    typedef struct {
        logic         rst_n;
        logic [N-1:0] valid;
        logic [N-1:0] last;
        logic [N*W-1:0] data;
        logic         tx_ready;
        outs_t        exp;
    } vec_t;

    // Reference model: who owns the stream, gap cycles remaining, idle run.
    typedef struct {
        int owner;
        int ptr;
        int gap_left;
        int idle_run;
        bit to_pulse;
    } mstate_t;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input outs_t act, input outs_t exp);
        check({tag, ".grant"},    32'(act.grant),    32'(exp.grant));
        check({tag, ".tx_valid"}, 32'(act.tx_valid), 32'(exp.tx_valid));
        check({tag, ".tx_data"},  32'(act.tx_data),  32'(exp.tx_data));
        check({tag, ".ready"},    32'(act.ready),    32'(exp.ready));
        check({tag, ".busy"},     32'(act.busy),     32'(exp.busy));
        check({tag, ".timeout"},  32'(act.timeout),  32'(exp.timeout));
    endtask

    function automatic outs_t get_a();
        outs_t o;
        o.grant = a_grant; o.tx_valid = a_valid; o.tx_data = a_data;
        o.ready = a_ready; o.busy = a_busy; o.timeout = a_timeout;
        return o;
    endfunction

    function automatic outs_t get_b();
        outs_t o;
        o.grant = b_grant; o.tx_valid = b_valid; o.tx_data = b_data;
        o.ready = b_ready; o.busy = b_busy; o.timeout = b_timeout;
        return o;
    endfunction

    function automatic outs_t mk_out(input logic [N-1:0] g, input logic v, input logic [W-1:0] d,
                                     input logic [N-1:0] r, input logic b, input logic t);
        outs_t o;
        o.grant = g; o.tx_valid = v; o.tx_data = d; o.ready = r; o.busy = b; o.timeout = t;
        return o;
    endfunction

    function automatic void push(input logic rs, input logic [N-1:0] v, input logic [N-1:0] l,
                                 input logic [N*W-1:0] d, input logic rdy, input outs_t e);
        vec_t x;
        x.rst_n = rs; x.valid = v; x.last = l; x.data = d; x.tx_ready = rdy; x.exp = e;
        vecs.push_back(x);
    endfunction

    function automatic mstate_t model_reset();
        mstate_t s;
        s.owner = -1; s.ptr = 0; s.gap_left = 0; s.idle_run = 0; s.to_pulse = 1'b0;
        return s;
    endfunction

    function automatic outs_t model_out(input mstate_t s);
        outs_t o;
        o = mk_out('0, 1'b0, '0, '0, 1'b0, 1'b0);
        if (rst_n) begin
            if (s.owner >= 0) begin
                o.grant[s.owner] = 1'b1;
                o.tx_valid       = req_valid[s.owner];
                o.tx_data        = req_data[s.owner*W +: W];
                o.ready[s.owner] = tx_ready;
            end
            o.busy    = (s.owner >= 0) || (s.gap_left > 0);
            o.timeout = s.to_pulse;
        end
        return o;
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input int gap);
        mstate_t n;
        bit done;
        n = s;
        n.to_pulse = 1'b0;
        done = 1'b0;
        if (!rst_n) return model_reset();
        if (s.owner >= 0) begin
            if (req_valid[s.owner] && tx_ready && req_last[s.owner]) begin
                done = 1'b1;
            end else if (!req_valid[s.owner]) begin
                n.idle_run = s.idle_run + 1;
                if (n.idle_run == TO) begin
                    n.to_pulse = 1'b1;
                    done = 1'b1;
                end
            end else begin
                n.idle_run = 0;
            end
            if (done) begin
                n.owner = -1;
                n.gap_left = gap;
                n.idle_run = 0;
            end
        end else if (s.gap_left > 0) begin
            n.gap_left = s.gap_left - 1;
        end else begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (s.ptr + i) % N;
                if (req_valid[k] && n.owner < 0) begin
                    n.owner = k;
                    n.ptr = (k + 1) % N;
                    n.idle_run = 0;
                end
            end
        end
        return n;
    endfunction

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l,
                         input logic [N*W-1:0] d, input logic rdy);
        req_valid = v; req_last = l; req_data = d; tx_ready = rdy;
    endtask

    // Advance to the next falling edge, apply inputs, and settle.
    task automatic step(input logic [N-1:0] v, input logic [N-1:0] l,
                        input logic [N*W-1:0] d, input logic rdy);
        @(negedge clk);
        drive(v, l, d, rdy);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive('0, '0, '0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    outs_t   z;
    mstate_t ms_a, ms_b;

    initial begin
        z = mk_out('0, 1'b0, '0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        drive('0, '0, '0, 1'b0);
        #1;
        check_outs("reset_async_a", get_a(), z);
        check_outs("reset_async_b", get_b(), z);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outs("reset_hold_a", get_a(), z);

        // ---- vector table ----
        // 3-byte frame from req1 with a 2-cycle gap after it.
        push(1, 4'b0010, 4'b0000, 32'h0000_A100, 1, z);
        push(1, 4'b0010, 4'b0000, 32'h0000_A100, 1, mk_out(4'b0010, 1, 8'hA1, 4'b0010, 1, 0));
        push(1, 4'b0010, 4'b0000, 32'h0000_A200, 1, mk_out(4'b0010, 1, 8'hA2, 4'b0010, 1, 0));
        push(1, 4'b0010, 4'b0010, 32'h0000_A300, 1, mk_out(4'b0010, 1, 8'hA3, 4'b0010, 1, 0));
        push(1, 4'b0000, 4'b0000, 32'h0, 1, mk_out('0, 0, 8'h00, '0, 1, 0));
        push(1, 4'b0000, 4'b0000, 32'h0, 1, mk_out('0, 0, 8'h00, '0, 1, 0));
        push(1, 4'b0000, 4'b0000, 32'h0, 1, z);
        // All four requesters hold single-byte frames; pointer restarts at 0.
        push(0, 4'b0000, 4'b0000, 32'h0, 1, z);
        for (int r = 0; r < 5; r++) begin
            logic [N-1:0] oh;
            logic [W-1:0] bt;
            oh = '0;
            oh[r % N] = 1'b1;
            bt = W'(8'h10 * ((r % N) + 1));
            push(1, 4'b1111, 4'b1111, 32'h4030_2010, 1, z);
            push(1, 4'b1111, 4'b1111, 32'h4030_2010, 1, mk_out(oh, 1, bt, oh, 1, 0));
            push(1, 4'b1111, 4'b1111, 32'h4030_2010, 1, mk_out('0, 0, 8'h00, '0, 1, 0));
            push(1, 4'b1111, 4'b1111, 32'h4030_2010, 1, mk_out('0, 0, 8'h00, '0, 1, 0));
        end
        // req2 frame with tx_ready toggled 1,0,0,1 while req0 waits.
        push(0, 4'b0000, 4'b0000, 32'h0, 1, z);
        push(1, 4'b0100, 4'b0001, 32'h00C1_000E, 1, z);
        push(1, 4'b0101, 4'b0001, 32'h00C1_000E, 1, mk_out(4'b0100, 1, 8'hC1, 4'b0100, 1, 0));
        push(1, 4'b0101, 4'b0001, 32'h00C2_000E, 0, mk_out(4'b0100, 1, 8'hC2, 4'b0000, 1, 0));
        push(1, 4'b0101, 4'b0001, 32'h00C2_000E, 0, mk_out(4'b0100, 1, 8'hC2, 4'b0000, 1, 0));
        push(1, 4'b0101, 4'b0101, 32'h00C2_000E, 1, mk_out(4'b0100, 1, 8'hC2, 4'b0100, 1, 0));
        push(1, 4'b0001, 4'b0001, 32'h0000_000E, 1, mk_out('0, 0, 8'h00, '0, 1, 0));
        push(1, 4'b0001, 4'b0001, 32'h0000_000E, 1, mk_out('0, 0, 8'h00, '0, 1, 0));
        push(1, 4'b0001, 4'b0001, 32'h0000_000E, 1, z);
        push(1, 4'b0001, 4'b0001, 32'h0000_000E, 1, mk_out(4'b0001, 1, 8'h0E, 4'b0001, 1, 0));
        push(1, 4'b0000, 4'b0000, 32'h0, 1, mk_out('0, 0, 8'h00, '0, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n;
            drive(vecs[i].valid, vecs[i].last, vecs[i].data, vecs[i].tx_ready);
            #1;
            check_outs($sformatf("vec%0d", i), get_a(), vecs[i].exp);
        end

        // ---- watchdog: req3 sends 0x55 then stalls; req0 is next ----
        do_reset();
        step(4'b1000, 4'b0000, 32'h5500_0000, 1);
        check("to_idle.grant", 32'(a_grant), 32'h0);
        step(4'b1000, 4'b0000, 32'h5500_0000, 1);
        check("to_byte.data", 32'(a_data), 32'h55);
        check("to_byte.grant", 32'(a_grant), 32'h8);
        for (int k = 1; k <= TO; k++) begin
            step(4'b0001, 4'b0001, 32'h5500_0077, 1);
            check($sformatf("to_wait%0d.timeout", k), 32'(a_timeout), 32'h0);
            check($sformatf("to_wait%0d.ready", k), 32'(a_ready), 32'h8);
        end
        step(4'b0001, 4'b0001, 32'h5500_0077, 1);
        check("to_pulse.timeout", 32'(a_timeout), 32'h1);
        check("to_pulse.grant", 32'(a_grant), 32'h0);
        check("to_pulse.busy", 32'(a_busy), 32'h1);
        step(4'b0001, 4'b0001, 32'h5500_0077, 1);
        check("to_gap.timeout", 32'(a_timeout), 32'h0);
        check("to_gap.busy", 32'(a_busy), 32'h1);
        step(4'b0001, 4'b0001, 32'h5500_0077, 1);
        check("to_idle2.busy", 32'(a_busy), 32'h0);
        step(4'b0001, 4'b0001, 32'h5500_0077, 1);
        check("to_next.grant", 32'(a_grant), 32'h1);
        check("to_next.data", 32'(a_data), 32'h77);

        // ---- reset during byte 2 of a req0 frame ----
        do_reset();
        step(4'b0001, 4'b0000, 32'h0000_00B1, 1);
        step(4'b0001, 4'b0000, 32'h0000_00B1, 1);
        check("rst_b1.data", 32'(a_data), 32'hB1);
        step(4'b0001, 4'b0000, 32'h0000_00B2, 1);
        check("rst_b2.data", 32'(a_data), 32'hB2);
        #2 rst_n = 1'b0;
        #1;
        check_outs("rst_mid", get_a(), z);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b1001, 4'b0000, 32'hD300_00B3, 1);
        #1;
        check("rst_rel.grant", 32'(a_grant), 32'h0);
        step(4'b1001, 4'b0000, 32'hD300_00B3, 1);
        check("rst_ptr0.grant", 32'(a_grant), 32'h1);
        check("rst_ptr0.data", 32'(a_data), 32'hB3);

        // ---- zero-gap build: back-to-back frames from req0 and req1 ----
        do_reset();
        step(4'b0011, 4'b0011, 32'h0000_D1D0, 1);
        check("gap0_idle.grant", 32'(b_grant), 32'h0);
        step(4'b0011, 4'b0011, 32'h0000_D1D0, 1);
        check("gap0_f0.grant", 32'(b_grant), 32'h1);
        check("gap0_f0.data", 32'(b_data), 32'hD0);
        step(4'b0011, 4'b0011, 32'h0000_D1D0, 1);
        check("gap0_idle2.busy", 32'(b_busy), 32'h0);
        check("gap0_idle2.valid", 32'(b_valid), 32'h0);
        check("gapA_gap.busy", 32'(a_busy), 32'h1);
        step(4'b0011, 4'b0011, 32'h0000_D1D0, 1);
        check("gap0_f1.grant", 32'(b_grant), 32'h2);
        check("gap0_f1.valid", 32'(b_valid), 32'h1);
        check("gap0_f1.data", 32'(b_data), 32'hD1);

        // ---- random traffic against the reference model ----
        do_reset();
        ms_a = model_reset();
        ms_b = model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int pv;
            logic [N-1:0] v, l;
            pv = (((cyc / 400) % 3) == 2) ? 10 : 70;
            for (int k = 0; k < N; k++) begin
                v[k] = ($urandom_range(0, 99) < pv);
                l[k] = ($urandom_range(0, 99) < 30);
            end
            @(negedge clk);
            rst_n = ($urandom_range(0, 299) != 0);
            drive(v, l, $urandom(), ($urandom_range(0, 99) < 70));
            #1;
            check_outs($sformatf("rnd%0d_a", cyc), get_a(), model_out(ms_a));
            check_outs($sformatf("rnd%0d_b", cyc), get_b(), model_out(ms_b));
            ms_a = model_next(ms_a, GAP_A);
            ms_b = model_next(ms_b, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
